// File: rtl/fifo_nibble_reader_pkg.sv
// fifo_rd_pkg: shared state encoding, nibble width and slot mapping for the FIFO nibble reader.
package fifo_rd_pkg;
    localparam int NIBBLE_W = 4;
    typedef enum logic [1:0] {FETCH, PULSE, SETTLE, HOLD} state_e;
    function automatic int unsigned slot_of(input int unsigned cnt, input int unsigned nibbles, input bit lsn_first);
        return lsn_first ? cnt : nibbles - 1 - cnt;
    endfunction
endpackage

// File: rtl/fifo_nibble_reader_if.sv
// fifo_nibble_reader_if: FIFO read side, flush and packed-word valid/ready bundle.
interface fifo_nibble_reader_if
    import fifo_rd_pkg::*;
#(
    parameter int NIBBLES = 2
);
    logic [NIBBLE_W-1:0]         fifo_dout;
    logic                        fifo_empty;
    logic                        fifo_read;
    logic                        flush;
    logic [NIBBLE_W*NIBBLES-1:0] out_data;
    logic                        out_valid;
    logic                        out_ready;
    logic                        busy;
    modport master (
        input  fifo_dout, fifo_empty, flush, out_ready,
        output fifo_read, out_data, out_valid, busy
    );
    modport slave (
        output fifo_dout, fifo_empty, flush, out_ready,
        input  fifo_read, out_data, out_valid, busy
    );
endinterface

// File: rtl/fifo_nibble_reader_packer.sv
// nibble_packer: word assembly register with per-slot nibble write and clear.
module nibble_packer
    import fifo_rd_pkg::*;
#(
    parameter int NIBBLES = 2,
    parameter int SW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        wr_en,
    input  logic [SW-1:0]               slot,
    input  logic [NIBBLE_W-1:0]         nib,
    output logic [NIBBLE_W*NIBBLES-1:0] data
);
    logic [NIBBLE_W*NIBBLES-1:0] data_q, data_d;
    always_comb begin
        data_d = data_q;
        if (clear)
            data_d = '0;
        else if (wr_en)
            data_d[slot*NIBBLE_W +: NIBBLE_W] = nib;
    end
    always_ff @(posedge clk) begin
        if (rst)
            data_q <= '0;
        else
            data_q <= data_d;
    end
    assign data = data_q;
endmodule

// File: rtl/fifo_nibble_reader.sv
// fifo_nibble_reader: drains a ripple FIFO nibble by nibble, with a settle gap after each read, into packed words.
module fifo_nibble_reader
    import fifo_rd_pkg::*;
#(
    parameter int NIBBLES       = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter int LSN_FIRST     = 1
) (
    input logic                  clk,
    input logic                  clr,
    fifo_nibble_reader_if.master bus
);
    localparam int NW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    state_e        state_q, state_d;
    logic [NW-1:0] nib_cnt_q, nib_cnt_d;
    logic [SW-1:0] settle_cnt_q, settle_cnt_d;
    logic          fifo_read_q, fifo_read_d;
    logic          out_valid_q, out_valid_d;
    logic          wr_en, clr_pack;
    logic [NW-1:0] slot;
    assign slot = NW'(slot_of(32'(nib_cnt_q), NIBBLES, LSN_FIRST != 0));
    always_comb begin
        state_d      = state_q;
        nib_cnt_d    = nib_cnt_q;
        settle_cnt_d = settle_cnt_q;
        wr_en        = 1'b0;
        clr_pack     = 1'b0;
        case (state_q)
            FETCH: begin
                if (bus.flush) begin
                    nib_cnt_d = '0;
                    clr_pack  = 1'b1;
                end else if (!bus.fifo_empty) begin
                    wr_en   = 1'b1;
                    state_d = PULSE;
                end
            end
            PULSE: begin
                state_d      = SETTLE;
                settle_cnt_d = '0;
            end
            SETTLE: begin
                if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) begin
                    nib_cnt_d = (nib_cnt_q == NW'(NIBBLES - 1)) ? '0 : nib_cnt_q + NW'(1);
                    state_d   = (nib_cnt_q == NW'(NIBBLES - 1)) ? HOLD : FETCH;
                end else begin
                    settle_cnt_d = settle_cnt_q + SW'(1);
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d  = FETCH;
                    clr_pack = 1'b1;
                end
            end
            default: state_d = FETCH;
        endcase
        // strobe and valid are registered copies of the next state's decode
        fifo_read_d = state_d == PULSE;
        out_valid_d = state_d == HOLD;
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= FETCH;
            nib_cnt_q    <= '0;
            settle_cnt_q <= '0;
            fifo_read_q  <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            nib_cnt_q    <= nib_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            fifo_read_q  <= fifo_read_d;
            out_valid_q  <= out_valid_d;
        end
    end
    nibble_packer #(.NIBBLES(NIBBLES), .SW(NW)) u_packer (
        .clk   (clk),
        .rst   (clr),
        .clear (clr_pack),
        .wr_en (wr_en),
        .slot  (slot),
        .nib   (bus.fifo_dout),
        .data  (bus.out_data)
    );
    assign bus.fifo_read = fifo_read_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state_q != FETCH) || (nib_cnt_q != '0);
endmodule

// File: tb/tb_fifo_nibble_reader.sv
// tb_fifo_nibble_reader: directed and random checks of the nibble reader against a queue-based FIFO/word model.
module tb_fifo_nibble_reader;
    localparam int NIB = 2;
    logic clk;
    logic clr;
    fifo_nibble_reader_if #(.NIBBLES(NIB)) b0 ();
    fifo_nibble_reader_if #(.NIBBLES(NIB)) b1 ();
    fifo_nibble_reader #(.NIBBLES(NIB), .SETTLE_CYCLES(2), .LSN_FIRST(1)) dut0 (.clk(clk), .clr(clr), .bus(b0));
    fifo_nibble_reader #(.NIBBLES(NIB), .SETTLE_CYCLES(2), .LSN_FIRST(0)) dut1 (.clk(clk), .clr(clr), .bus(b1));
    assign b1.fifo_dout  = b0.fifo_dout;
    assign b1.fifo_empty = b0.fifo_empty;
    assign b1.flush      = b0.flush;
    assign b1.out_ready  = b0.out_ready;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int words_seen = 0;
    int vcount = 0;
    bit stall = 0;
    logic [3:0] fq[$];
    logic [3:0] partial[$];
    logic [7:0] exp0[$];
    logic [7:0] exp1[$];
    int pulses[$];
    int rises[$];
    logic [7:0] last_word0, last_word1;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, want);
        end
    endtask
    task automatic drive();
        b0.fifo_empty = stall || (fq.size() == 0);
        b0.fifo_dout  = (fq.size() != 0) ? fq[0] : 4'($urandom);
    endtask
    task automatic tick();
        logic c, v, r, pe, pr, pv;
        logic [3:0] pd;
        logic [7:0] d0, d1, w0, w1;
        c = clr; v = b0.out_valid; r = b0.out_ready; d0 = b0.out_data; d1 = b1.out_data;
        pe = b0.fifo_empty; pd = b0.fifo_dout; pr = b0.fifo_read; pv = b0.out_valid;
        @(posedge clk);
        #1;
        cyc++;
        if (c) begin
            partial.delete();
            exp0.delete();
            exp1.delete();
        end else begin
            if (v === 1'b1 && r === 1'b1) begin
                chk("word_expected", 32'(exp0.size() > 0), 1);
                if (exp0.size() > 0) begin
                    chk("word_lsn_first", d0, exp0.pop_front());
                    chk("word_msn_first", d1, exp1.pop_front());
                end
                last_word0 = d0;
                last_word1 = d1;
                words_seen++;
            end
            if (b0.fifo_read === 1'b1) begin
                chk("read_after_nonempty", pe, 0);
                chk("read_one_cycle", pr, 0);
                pulses.push_back(cyc);
                partial.push_back(pd);
                if (fq.size() > 0) void'(fq.pop_front());
                if (partial.size() == NIB) begin
                    w0 = 0;
                    w1 = 0;
                    for (int i = 0; i < NIB; i++) begin
                        w0 |= 8'(partial[i]) << (4 * i);
                        w1 |= 8'(partial[i]) << (4 * (NIB - 1 - i));
                    end
                    exp0.push_back(w0);
                    exp1.push_back(w1);
                    partial.delete();
                end
            end
            if (b0.out_valid === 1'b1 && pv !== 1'b1) rises.push_back(cyc);
        end
        if (b0.out_valid === 1'b1) vcount++;
        drive();
    endtask
    task automatic wait_pulse(input string tag, input int max);
        logic seen;
        seen = 0;
        for (int i = 0; i < max && !seen; i++) begin
            tick();
            seen = b0.fifo_read;
        end
        chk(tag, 32'(seen), 1);
    endtask
    task automatic wait_valid(input string tag, input int max);
        logic seen;
        seen = 0;
        for (int i = 0; i < max && !seen; i++) begin
            tick();
            seen = b0.out_valid;
        end
        chk(tag, 32'(seen), 1);
    endtask
    task automatic run_idle(input string tag, input int max, input bit rnd);
        logic done;
        done = 0;
        for (int i = 0; i < max && !done; i++) begin
            if (rnd) begin
                b0.out_ready = 1'($urandom_range(0, 1));
                stall = ($urandom_range(0, 3) == 0);
            end
            tick();
            done = (fq.size() == 0) && (partial.size() == 0) && (exp0.size() == 0) && (b0.busy === 1'b0);
        end
        stall = 0;
        b0.out_ready = 1'b1;
        drive();
        chk(tag, 32'(done), 1);
    endtask
    initial begin
        int start, np, ws;
        logic [7:0] snap;
        clr = 1'b1;
        b0.flush = 1'b0;
        b0.out_ready = 1'b1;
        fq = '{4'h5, 4'hA};
        drive();
        repeat (2) begin
            tick();
            chk("rst_read", b0.fifo_read, 0);
            chk("rst_valid", b0.out_valid, 0);
            chk("rst_data", b0.out_data, 0);
            chk("rst_busy", b0.busy, 0);
        end
        clr = 1'b0;
        pulses.delete(); rises.delete(); vcount = 0;
        start = cyc;
        repeat (12) tick();
        chk("basic_pulse_count", pulses.size(), 2);
        if (pulses.size() == 2) begin
            chk("basic_first_pulse", pulses[0], start + 1);
            chk("basic_pulse_gap", pulses[1] - pulses[0], 4);
        end
        chk("basic_rise_count", rises.size(), 1);
        if (rises.size() == 1 && pulses.size() > 0) chk("basic_latency", rises[0] - pulses[0], 7);
        chk("basic_valid_width", vcount, 1);
        chk("basic_words", words_seen, 1);
        chk("basic_word0", last_word0, 8'hA5);
        chk("basic_word1", last_word1, 8'h5A);
        fq.push_back(4'h5);
        drive();
        pulses.delete();
        wait_pulse("stall_first_pulse", 10);
        repeat (10) tick();
        chk("stall_no_read", pulses.size(), 1);
        chk("stall_busy", b0.busy, 1);
        fq.push_back(4'hA);
        drive();
        run_idle("stall_done", 50, 0);
        chk("stall_word", last_word0, 8'hA5);
        b0.out_ready = 1'b0;
        repeat (4) fq.push_back(4'($urandom));
        drive();
        wait_valid("bp_valid_rise", 40);
        snap = b0.out_data;
        np = pulses.size();
        repeat (5) begin
            tick();
            chk("bp_data_stable", b0.out_data, snap);
            chk("bp_valid_held", b0.out_valid, 1);
        end
        chk("bp_no_read", pulses.size(), np);
        b0.out_ready = 1'b1;
        tick();
        chk("bp_accept_valid", b0.out_valid, 0);
        chk("bp_accept_noread", b0.fifo_read, 0);
        tick();
        chk("bp_resume_read", b0.fifo_read, 1);
        run_idle("bp_done", 60, 0);
        fq.push_back(4'h3);
        drive();
        wait_pulse("flush_first_pulse", 10);
        repeat (4) tick();
        b0.flush = 1'b1;
        tick();
        b0.flush = 1'b0;
        partial.delete();
        chk("flush_busy", b0.busy, 0);
        fq.push_back(4'h1);
        fq.push_back(4'h2);
        drive();
        run_idle("flush_done", 50, 0);
        chk("flush_word", last_word0, 8'h21);
        fq.push_back(4'h4);
        fq.push_back(4'h6);
        drive();
        wait_pulse("settle_flush_pulse", 10);
        b0.flush = 1'b1;
        tick();
        b0.flush = 1'b0;
        run_idle("settle_flush_done", 50, 0);
        chk("settle_flush_word", last_word0, 8'h64);
        fq.push_back(4'h9);
        fq.push_back(4'hB);
        drive();
        wait_pulse("midrst_pulse1", 10);
        wait_pulse("midrst_pulse2", 10);
        tick();
        clr = 1'b1;
        ws = words_seen;
        tick();
        clr = 1'b0;
        chk("midrst_busy", b0.busy, 0);
        chk("midrst_read", b0.fifo_read, 0);
        chk("midrst_valid", b0.out_valid, 0);
        fq.push_back(4'h7);
        fq.push_back(4'h8);
        drive();
        run_idle("midrst_done", 50, 0);
        chk("midrst_words", words_seen, ws + 1);
        chk("midrst_word", last_word0, 8'h87);
        ws = words_seen;
        repeat (40) fq.push_back(4'($urandom));
        drive();
        run_idle("rnd_done", 3000, 1);
        chk("rnd_words", words_seen, ws + 20);
        chk("rnd_scoreboard_empty", exp0.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
